// File: rtl/flappy_pkg.sv
// Shared types and pixel geometry for the flappy playfield blocks.
// The pipe generator's gap-narrowing ramp is enabled by PIPE_GEN_RAMP_EN.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } pipe_state_t;

  typedef logic [15:0] pipe_t;

  localparam int SCREEN_H_PX = 480;
  localparam int MARGIN_PX   = 30;
  localparam int PIPE_W_PX   = 60;
  localparam int SPACING_PX  = 240;
  localparam int GAP_H_PX    = 90;
  localparam int PIPE_PITCH  = PIPE_W_PX + SPACING_PX;

  localparam int GAP_FLOOR_PX = 60;
  localparam int GAP_STEP_PX  = 2;

  localparam pipe_t LFSR_TAPS = 16'hB400;
  localparam pipe_t LFSR_SEED = 16'hACE1;

  // One Galois right-shift step.
  function automatic pipe_t lfsr_next(input pipe_t v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous load of SEED and a step enable.
// Exposes the look-ahead value so callers can use the post-step word in the same cycle.
module lfsr16
  import flappy_pkg::*;
#(
  parameter pipe_t SEED = LFSR_SEED
) (
  input  logic  clk,
  input  logic  load,
  input  logic  step,
  output pipe_t value,
  output pipe_t next_value
);

  if (SEED == 16'h0000) begin : g_bad_seed
    $error("lfsr16: SEED must be non-zero");
  end

  pipe_t lfsr_q, lfsr_d;

  assign next_value = lfsr_next(lfsr_q);
  assign value      = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (step) begin
      lfsr_d = next_value;
    end
  end

  always_ff @(posedge clk) begin
    lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/pipe_gen.sv
// Pipe generator: scroll tracking, emit timing and LFSR-drawn gap positions.
// Define PIPE_GEN_RAMP_EN to narrow the gap by 2 px every 8 emits (floor 60 px).
module pipe_gen
  import flappy_pkg::*;
#(
  parameter int    SCREEN_H  = SCREEN_H_PX,
  parameter int    MARGIN    = MARGIN_PX,
  parameter int    GAP_H     = GAP_H_PX,
  parameter int    PIPE_W    = PIPE_W_PX,
  parameter int    SPACING   = SPACING_PX,
  parameter int    SCROLL_PX = 2,
  parameter pipe_t SEED      = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        game_over,
  output logic [15:0] nxt_pipe,
  output logic        pipe_en,
  output logic [8:0]  scroll_off,
  output logic [15:0] gap_h,
  output logic [15:0] pipe_cnt,
  output logic        running,
  output pipe_state_t state_dbg
);

  localparam int    PITCH      = PIPE_W + SPACING;
  localparam int    RANGE_MAX  = SCREEN_H - 2 * MARGIN - GAP_H + 1;
  localparam pipe_t PITCH16    = pipe_t'(PITCH);
  localparam pipe_t SCROLL16   = pipe_t'(SCROLL_PX);
  localparam pipe_t MARGIN16   = pipe_t'(MARGIN);
  localparam pipe_t GAP16      = pipe_t'(GAP_H);
  localparam pipe_t SPAN16     = pipe_t'(SCREEN_H - 2 * MARGIN + 1);

  // The folding of next[8:0] into the gap range uses one subtract only.
  if (RANGE_MAX <= 256 || RANGE_MAX > 512) begin : g_bad_range
    $error("pipe_gen: gap range must lie in (256, 512]");
  end
  if (PITCH > 512 || PITCH < 1) begin : g_bad_pitch
    $error("pipe_gen: pitch must fit the 9-bit scroll offset");
  end

  pipe_state_t state_q, state_d;
  logic        first_q, first_d;
  pipe_t       nxt_pipe_q, nxt_pipe_d;
  logic        pipe_en_q, pipe_en_d;
  logic [8:0]  scroll_q, scroll_d;
  pipe_t       cnt_q, cnt_d;
  logic        emit;
  pipe_t       scroll_sum, scroll_wrap, draw, gap_range, gap_cur;
  pipe_t       lfsr_val, lfsr_nxt;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .load       (rst),
    .step       (emit),
    .value      (lfsr_val),
    .next_value (lfsr_nxt)
  );

  assign gap_range = SPAN16 - gap_cur;

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    nxt_pipe_d  = nxt_pipe_q;
    pipe_en_d   = 1'b0;
    scroll_d    = scroll_q;
    cnt_d       = cnt_q;
    emit        = 1'b0;
    scroll_sum  = pipe_t'(scroll_q) + SCROLL16;
    scroll_wrap = scroll_sum - PITCH16;
    draw        = {7'd0, lfsr_nxt[8:0]};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          first_d = 1'b1;
        end
      end
      ST_RUN: begin
        // game_over takes priority over a same-cycle frame_tick.
        if (game_over) begin
          state_d = ST_FROZEN;
        end else if (frame_tick) begin
          if (first_q) begin
            emit    = 1'b1;
            first_d = 1'b0;
          end else if (scroll_sum >= PITCH16) begin
            emit     = 1'b1;
            scroll_d = scroll_wrap[8:0];
          end else begin
            scroll_d = scroll_sum[8:0];
          end
        end
      end
      ST_FROZEN: begin
        state_d = ST_FROZEN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (emit) begin
      if (draw >= gap_range) begin
        draw = draw - gap_range;
      end
      pipe_en_d  = 1'b1;
      nxt_pipe_d = MARGIN16 + draw;
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      first_q    <= 1'b0;
      nxt_pipe_q <= '0;
      pipe_en_q  <= 1'b0;
      scroll_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      nxt_pipe_q <= nxt_pipe_d;
      pipe_en_q  <= pipe_en_d;
      scroll_q   <= scroll_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef PIPE_GEN_RAMP_EN
  localparam pipe_t FLOOR16 = pipe_t'(GAP_FLOOR_PX);
  localparam pipe_t STEP16  = pipe_t'(GAP_STEP_PX);

  localparam int RANGE_MIN_GAP = SCREEN_H - 2 * MARGIN - GAP_FLOOR_PX + 1;
  if (RANGE_MIN_GAP > 512) begin : g_bad_ramp_range
    $error("pipe_gen: gap range at the ramp floor exceeds 512");
  end

  pipe_t      gap_q, gap_d;
  logic [2:0] ramp_q, ramp_d;

  // The narrowed gap is registered with the 8th emit, so it shapes the next draw.
  always_comb begin
    gap_d  = gap_q;
    ramp_d = ramp_q;
    if (emit) begin
      ramp_d = ramp_q + 3'd1;
      if (ramp_q == 3'd7) begin
        gap_d = (gap_q >= FLOOR16 + STEP16) ? gap_q - STEP16 : FLOOR16;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q  <= GAP16;
      ramp_q <= '0;
    end else begin
      gap_q  <= gap_d;
      ramp_q <= ramp_d;
    end
  end

  assign gap_cur = gap_q;
`else
  assign gap_cur = GAP16;
`endif

  assign nxt_pipe   = nxt_pipe_q;
  assign pipe_en    = pipe_en_q;
  assign scroll_off = scroll_q;
  assign gap_h      = gap_cur;
  assign pipe_cnt   = cnt_q;
  assign running    = (state_q == ST_RUN);
  assign state_dbg  = state_q;

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_val;

endmodule

// File: tb/tb_pipe_gen.sv
// Self-checking bench for pipe_gen: table of emit checkpoints, scoreboard of expected
// emits, and hand sequences for reset-in-flight, game_over/tick collision and the gap ramp.
module tb_pipe_gen;
  import flappy_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        game_over = 1'b0;
  logic [15:0] nxt_pipe;
  logic        pipe_en;
  logic [8:0]  scroll_off;
  logic [15:0] gap_h;
  logic [15:0] pipe_cnt;
  logic        running;
  pipe_state_t state_dbg;

  pipe_gen dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .game_over  (game_over),
    .nxt_pipe   (nxt_pipe),
    .pipe_en    (pipe_en),
    .scroll_off (scroll_off),
    .gap_h      (gap_h),
    .pipe_cnt   (pipe_cnt),
    .running    (running),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // scoreboard: {nxt_pipe, pipe_cnt} per expected emit
  logic [31:0] exp_q[$];

  // reference model
  pipe_state_t m_state;
  logic        m_first;
  int          m_scroll;
  logic [15:0] m_lfsr;
  logic [15:0] m_cnt;
  logic [15:0] m_gap;
  int          m_emits;

  typedef struct {
    int          ticks;
    logic [15:0] exp_pipe;
    logic [15:0] exp_cnt;
    logic [8:0]  exp_scroll;
  } vec_t;

  vec_t vecs[4];

`ifdef PIPE_GEN_RAMP_EN
  localparam logic [15:0] GAP_AT_8  = 16'd88;
  localparam logic [15:0] GAP_AT_16 = 16'd86;
`else
  localparam logic [15:0] GAP_AT_8  = 16'd90;
  localparam logic [15:0] GAP_AT_16 = 16'd90;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic [15:0] sh;
    sh = {1'b0, v[15:1]};
    if (v[0]) sh = sh ^ 16'hB400;
    return sh;
  endfunction

  task automatic model_reset();
    m_state  = ST_IDLE;
    m_first  = 1'b0;
    m_scroll = 0;
    m_lfsr   = 16'hACE1;
    m_cnt    = 16'd0;
    m_gap    = 16'd90;
    m_emits  = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; game_over = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (m_state == ST_IDLE) begin
      m_state = ST_RUN;
      m_first = 1'b1;
    end
  endtask

  // Drive one frame_tick (optionally with game_over) and check the strobe timing.
  task automatic tick(input logic go);
    logic exp_emit;
    int   r, rng;
    exp_emit = 1'b0;
    if (m_state == ST_RUN) begin
      if (go) begin
        m_state = ST_FROZEN;
      end else if (m_first) begin
        exp_emit = 1'b1;
        m_first  = 1'b0;
      end else begin
        m_scroll += 2;
        if (m_scroll >= 300) begin
          exp_emit = 1'b1;
          m_scroll -= 300;
        end
      end
    end
    if (exp_emit) begin
      m_lfsr = ref_step(m_lfsr);
      r   = int'(m_lfsr[8:0]);
      rng = 480 - 60 - int'(m_gap) + 1;
      if (r >= rng) r -= rng;
      m_cnt++;
      exp_q.push_back({16'(30 + r), m_cnt});
      m_emits++;
`ifdef PIPE_GEN_RAMP_EN
      if ((m_emits % 8) == 0 && m_gap > 16'd60) m_gap -= 16'd2;
`endif
    end
    frame_tick = 1'b1; game_over = go;
    @(posedge clk);
    #1 frame_tick = 1'b0; game_over = 1'b0;
    check("pipe_en_strobe", {31'd0, pipe_en}, {31'd0, exp_emit});
    @(posedge clk);
    #1 check("pipe_en_one_cycle", {31'd0, pipe_en}, 32'd0);
  endtask

  task automatic apply_table();
    for (int i = 0; i < 4; i++) begin
      repeat (vecs[i].ticks) tick(1'b0);
      check("tbl_nxt_pipe", nxt_pipe, vecs[i].exp_pipe);
      check("tbl_pipe_cnt", pipe_cnt, vecs[i].exp_cnt);
      check("tbl_scroll_off", scroll_off, vecs[i].exp_scroll);
    end
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (pipe_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_emit: got pipe_en=1 nxt_pipe=%0d expected no emit (t=%0t)", nxt_pipe, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("emit_nxt_pipe", nxt_pipe, e[31:16]);
        check("emit_pipe_cnt", pipe_cnt, e[15:0]);
        check("emit_gap_bound", {31'd0, (nxt_pipe + gap_h) <= 16'd450}, 32'd1);
      end
    end
  end

  initial begin
    vecs[0] = '{ticks: 1,   exp_pipe: 16'd142, exp_cnt: 16'd1, exp_scroll: 9'd0};
    vecs[1] = '{ticks: 149, exp_pipe: 16'd142, exp_cnt: 16'd1, exp_scroll: 9'd298};
    vecs[2] = '{ticks: 1,   exp_pipe: 16'd342, exp_cnt: 16'd2, exp_scroll: 9'd0};
    vecs[3] = '{ticks: 150, exp_pipe: 16'd186, exp_cnt: 16'd3, exp_scroll: 9'd0};

    do_reset();
    check("rst_pipe_en", {31'd0, pipe_en}, 32'd0);
    check("rst_nxt_pipe", nxt_pipe, 32'd0);
    check("rst_scroll_off", scroll_off, 32'd0);
    check("rst_pipe_cnt", pipe_cnt, 32'd0);
    check("rst_gap_h", gap_h, 32'd90);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // ticks and game_over in IDLE are ignored
    repeat (3) tick(1'b0);
    tick(1'b1);
    check("idle_running", {31'd0, running}, 32'd0);
    check("idle_scroll_off", scroll_off, 32'd0);
    check("idle_pipe_cnt", pipe_cnt, 32'd0);
    check("idle_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    pulse_start();
    check("start_running", {31'd0, running}, 32'd1);
    apply_table();

    // reset lands on the cycle of an emitting tick: the emit must not appear
    repeat (149) tick(1'b0);
    check("pre_rst_scroll", scroll_off, 32'd298);
    frame_tick = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0; rst = 1'b0;
    model_reset();
    check("midrst_pipe_en", {31'd0, pipe_en}, 32'd0);
    check("midrst_nxt_pipe", nxt_pipe, 32'd0);
    check("midrst_pipe_cnt", pipe_cnt, 32'd0);
    check("midrst_scroll", scroll_off, 32'd0);
    check("midrst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // replay must match the first run exactly
    pulse_start();
    apply_table();

    // start while running is ignored: next tick only scrolls
    pulse_start();
    check("restart_state", {30'd0, state_dbg}, {30'd0, ST_RUN});
    tick(1'b0);
    check("restart_scroll", scroll_off, 32'd2);
    repeat (148) tick(1'b0);

    // game_over on the emitting tick wins
    tick(1'b1);
    check("go_state", {30'd0, state_dbg}, {30'd0, ST_FROZEN});
    check("go_running", {31'd0, running}, 32'd0);
    check("go_scroll", scroll_off, 32'd298);
    check("go_nxt_pipe", nxt_pipe, 32'd186);
    check("go_pipe_cnt", pipe_cnt, 32'd3);
    repeat (3) tick(1'b0);
    pulse_start();
    check("frozen_state", {30'd0, state_dbg}, {30'd0, ST_FROZEN});
    check("frozen_scroll", scroll_off, 32'd298);
    check("frozen_nxt_pipe", nxt_pipe, 32'd186);

    // 16 emits: gap ramp (or constant gap in the default build)
    do_reset();
    pulse_start();
    for (int k = 0; k < 2600 && m_emits < 16; k++) begin
      int prev;
      prev = m_emits;
      tick(1'b0);
      if (m_emits != prev && m_emits == 8) check("gap_after_8", gap_h, GAP_AT_8);
      if (m_emits != prev && m_emits == 16) check("gap_after_16", gap_h, GAP_AT_16);
    end
    check("ramp_pipe_cnt", pipe_cnt, 32'd16);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
